// File: rtl/fcfs_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fcfs_burst_scheduler
// Description : First-come-first-served scheduler for four requesters.
//               Arrivals are queued in order. The queue head receives a
//               registered one-hot grant for burst_len cycles (0 counts as 1)
//               or until it drops its request.
//               Optional macro FCFS_GAP_CYCLE_EN inserts one grant-free
//               turnaround cycle after every grant.
// Revision    : 1.0 - initial release
// ============================================================================
module fcfs_burst_scheduler #(
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         rqst,
    input  logic [BURST_W-1:0] burst_len,
    output logic [3:0]         grant,
    output logic [1:0]         grant_id,
    output logic               grant_valid,
    output logic [2:0]         queue_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
`ifdef FCFS_GAP_CYCLE_EN
    localparam logic [1:0] S_GAP   = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;

    // Arrival queue: circular buffer of requester IDs
    logic [1:0]         r_fifo [4];
    logic [1:0]         r_rd;
    logic [1:0]         r_wr;
    logic [2:0]         r_count;
    logic [3:0]         r_pending;

    // Grant registers
    logic [3:0]         r_grant;
    logic [1:0]         r_owner;
    logic [BURST_W-1:0] r_cnt;

    // Combinational decisions for the coming edge
    logic [1:0]         w_head;
    logic               w_grant_end;
    logic               w_eval_head;
    logic               w_pop;
    logic               w_start;
    logic               w_discard;
    logic [3:0]         w_new;
    logic [2:0]         w_push_cnt;
    logic [1:0]         w_slot [4];
    logic [3:0]         w_pend_clr;
    logic [3:0]         w_grant_nxt;
    logic [1:0]         w_owner_nxt;
    logic [BURST_W-1:0] w_cnt_nxt;

    assign w_head = r_fifo[r_rd];

    // The current grant finishes on burst expiry or when the owner lets go
    assign w_grant_end = (r_state == S_GRANT) &&
                         ((r_cnt == BURST_W'(1)) || !rqst[r_owner]);

    // Head is examined whenever no grant is running after this edge would
    // otherwise leave the resource idle; with the gap option a finishing grant
    // defers head evaluation to the turnaround cycle.
`ifdef FCFS_GAP_CYCLE_EN
    assign w_eval_head = (r_state == S_IDLE) || (r_state == S_GAP);
`else
    assign w_eval_head = (r_state == S_IDLE) || w_grant_end;
`endif

    assign w_pop     = w_eval_head && (r_count != 3'd0);
    assign w_start   = w_pop && rqst[w_head];
    assign w_discard = w_pop && !rqst[w_head];

    // A requester joins the queue once: not already pending and not the owner
    assign w_new = rqst & ~r_pending & ~r_grant;

    // Simultaneous arrivals take consecutive slots in ascending index order
    always_comb begin
        w_push_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w_slot[i] = r_wr + w_push_cnt[1:0];
            if (w_new[i]) begin
                w_push_cnt = w_push_cnt + 3'd1;
            end
        end
    end

    // Pending flags drop when a grant finishes or a withdrawn head is discarded
    always_comb begin
        w_pend_clr = 4'b0000;
        if (w_grant_end) begin
            w_pend_clr = w_pend_clr | r_grant;
        end
        if (w_discard) begin
            w_pend_clr = w_pend_clr | (4'b0001 << w_head);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                w_next_state = w_start ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                if (w_grant_end) begin
`ifdef FCFS_GAP_CYCLE_EN
                    w_next_state = S_GAP;
`else
                    w_next_state = w_start ? S_GRANT : S_IDLE;
`endif
                end
            end
`ifdef FCFS_GAP_CYCLE_EN
            S_GAP: begin
                w_next_state = w_start ? S_GRANT : S_IDLE;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output logic: next grant vector, owner and burst counter
    always_comb begin
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (r_state == S_GRANT) begin
            if (w_grant_end) begin
                w_grant_nxt = 4'b0000;
                w_owner_nxt = 2'd0;
            end else begin
                w_cnt_nxt = r_cnt - BURST_W'(1);
            end
        end
        if (w_start) begin
            w_grant_nxt = 4'b0001 << w_head;
            w_owner_nxt = w_head;
            w_cnt_nxt   = (burst_len == '0) ? BURST_W'(1) : burst_len;
        end
    end

    // Grant registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= 4'b0000;
            r_owner <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Arrival queue and pending flags; pop and push may share an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_fifo[i] <= 2'd0;
            end
            r_rd      <= 2'd0;
            r_wr      <= 2'd0;
            r_count   <= 3'd0;
            r_pending <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_new[i]) begin
                    r_fifo[w_slot[i]] <= 2'(i);
                end
            end
            r_rd      <= r_rd + {1'b0, w_pop};
            r_wr      <= r_wr + w_push_cnt[1:0];
            r_count   <= r_count + w_push_cnt - {2'b00, w_pop};
            r_pending <= (r_pending & ~w_pend_clr) | w_new;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_owner;
    assign grant_valid = |r_grant;
    assign queue_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fcfs_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fcfs_burst_scheduler
// Description : Self-checking bench for fcfs_burst_scheduler. A queue-based
//               reference model tracks arrival order, pending requesters and
//               the remaining burst of the current owner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fcfs_burst_scheduler;

    localparam int BURST_W = 4;
`ifdef FCFS_GAP_CYCLE_EN
    localparam bit GAP_MODE = 1'b1;
`else
    localparam bit GAP_MODE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [3:0]         rqst = 4'b0000;
    logic [BURST_W-1:0] burst_len = BURST_W'(1);
    logic [3:0]         grant;
    logic [1:0]         grant_id;
    logic               grant_valid;
    logic [2:0]         queue_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_q[$];
    bit         m_pend [4];
    int         m_owner = -1;
    int         m_left  = 0;
    logic [3:0] exp_grant = 4'b0000;
    logic [2:0] exp_qc    = 3'd0;

    fcfs_burst_scheduler #(.BURST_W(BURST_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rqst       (rqst),
        .burst_len  (burst_len),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_owner   = -1;
        m_left    = 0;
        exp_grant = 4'b0000;
        exp_qc    = 3'd0;
    endtask

    // Apply inputs, advance one clock and update the model from the FCFS rules
    task automatic step(input logic [3:0] rq, input logic [BURST_W-1:0] bl);
        int arrivals[$];
        bit do_head;
        int h;
        rqst      = rq;
        burst_len = bl;
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (rq[i] && !m_pend[i] && m_owner != i) arrivals.push_back(i);
        do_head = 1'b1;
        if (m_owner >= 0) begin
            if (m_left == 1 || !rq[m_owner]) begin
                m_pend[m_owner] = 1'b0;
                m_owner = -1;
                do_head = !GAP_MODE;
            end else begin
                m_left--;
                do_head = 1'b0;
            end
        end
        if (do_head && m_q.size() > 0) begin
            h = m_q.pop_front();
            if (rq[h]) begin
                m_owner = h;
                m_left  = (bl == 0) ? 1 : int'(bl);
            end else begin
                m_pend[h] = 1'b0;
            end
        end
        foreach (arrivals[k]) begin
            m_q.push_back(arrivals[k]);
            m_pend[arrivals[k]] = 1'b1;
        end
        exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        exp_qc    = 3'(m_q.size());
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) step(4'b0000, BURST_W'(1));
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || queue_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: grant=%b valid=%b id=%0d qc=%0d, expected all zero",
                     grant, grant_valid, grant_id, queue_count);
        end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_single_burst();
        int run_len = 0;
        bit done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(4'b0100, BURST_W'(3));
            checks++;
            if (grant !== exp_grant || queue_count !== exp_qc) begin
                errors++;
                $display("FAIL single_burst c%0d: grant=%b qc=%0d, expected %b qc=%0d",
                         c, grant, queue_count, exp_grant, exp_qc);
            end
            if (grant == 4'b0100 && !done) run_len++;
            else if (run_len > 0) done = 1'b1;
        end
        checks++;
        if (run_len != 3) begin
            errors++;
            $display("FAIL single_burst_len: granted %0d cycles, expected 3", run_len);
        end
        drain();
    endtask

    task automatic test_pair();
        for (int c = 0; c < 7; c++) begin
            step(4'b1010, BURST_W'(2));
            checks++;
            if (grant !== exp_grant || queue_count !== exp_qc) begin
                errors++;
                $display("FAIL pair c%0d: grant=%b qc=%0d, expected %b qc=%0d",
                         c, grant, queue_count, exp_grant, exp_qc);
            end
        end
        drain();
    endtask

    task automatic test_ordered();
        logic [3:0] vec [3];
        int order[$];
        int exp_order [3];
        logic prev_v = 1'b0;
        logic [1:0] prev_id = 2'd0;
        vec[0] = 4'b1000; vec[1] = 4'b1001; vec[2] = 4'b1101;
        exp_order[0] = 3; exp_order[1] = 0; exp_order[2] = 2;
        for (int c = 0; c < 18; c++) begin
            step(vec[(c < 3) ? c : 2], BURST_W'(4));
            checks++;
            if (grant !== exp_grant || queue_count !== exp_qc) begin
                errors++;
                $display("FAIL ordered c%0d: grant=%b qc=%0d, expected %b qc=%0d",
                         c, grant, queue_count, exp_grant, exp_qc);
            end
            if (grant_valid && (!prev_v || grant_id != prev_id)) order.push_back(int'(grant_id));
            prev_v  = grant_valid;
            prev_id = grant_id;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (order.size() <= k || order[k] != exp_order[k]) begin
                errors++;
                $display("FAIL ordered_seq[%0d]: got %0d, expected %0d",
                         k, (order.size() > k) ? order[k] : -1, exp_order[k]);
            end
        end
        drain();
    endtask

    task automatic test_early_release();
        logic [3:0] vec [6];
        int owner1_cycles = 0;
        vec[0] = 4'b0010; vec[1] = 4'b1010; vec[2] = 4'b1010;
        vec[3] = 4'b1000; vec[4] = 4'b1000; vec[5] = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            step(vec[c], BURST_W'(8));
            checks++;
            if (grant !== exp_grant || queue_count !== exp_qc) begin
                errors++;
                $display("FAIL early_release c%0d: grant=%b qc=%0d, expected %b qc=%0d",
                         c, grant, queue_count, exp_grant, exp_qc);
            end
            if (grant == 4'b0010) owner1_cycles++;
            if (c == 3) begin
                checks++;
                if (grant !== 4'b1000) begin
                    errors++;
                    $display("FAIL early_handover: grant=%b, expected 1000", grant);
                end
            end
        end
        checks++;
        if (owner1_cycles != 2) begin
            errors++;
            $display("FAIL early_release_len: owner1 held %0d cycles, expected 2", owner1_cycles);
        end
        drain();
    endtask

    task automatic test_withdrawal();
        logic [3:0] vec [6];
        vec[0] = 4'b0001; vec[1] = 4'b0101; vec[2] = 4'b0001;
        vec[3] = 4'b0000; vec[4] = 4'b0000; vec[5] = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            step(vec[c], BURST_W'(2));
            checks++;
            if (grant !== exp_grant || queue_count !== exp_qc) begin
                errors++;
                $display("FAIL withdrawal c%0d: grant=%b qc=%0d, expected %b qc=%0d",
                         c, grant, queue_count, exp_grant, exp_qc);
            end
            if (c == 3) begin
                checks++;
                if (grant !== 4'b0000 || queue_count !== 3'd0) begin
                    errors++;
                    $display("FAIL withdrawal_discard: grant=%b qc=%0d, expected 0000 qc=0",
                             grant, queue_count);
                end
            end
        end
        drain();
    endtask

    task automatic test_random();
        logic [3:0] rq = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 4) == 0) rq[b] = ~rq[b];
            step(rq, BURST_W'($urandom_range(0, 15)));
            checks++;
            if (grant !== exp_grant || queue_count !== exp_qc ||
                grant_valid !== (exp_grant != 4'b0000) ||
                (grant_valid && (4'(1 << grant_id) !== grant))) begin
                errors++;
                $display("FAIL random c%0d: grant=%b id=%0d valid=%b qc=%0d, expected %b qc=%0d",
                         c, grant, grant_id, grant_valid, queue_count, exp_grant, exp_qc);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_burst();
        step(4'b0001, BURST_W'(5));
        step(4'b0111, BURST_W'(5));
        step(4'b0111, BURST_W'(5));
        step(4'b0111, BURST_W'(5));
        checks++;
        if (grant !== 4'b0001 || queue_count !== 3'd2) begin
            errors++;
            $display("FAIL midburst_setup: grant=%b qc=%0d, expected 0001 qc=2", grant, queue_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || queue_count !== 3'd0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: grant=%b qc=%0d valid=%b, expected 0000 qc=0 valid=0",
                     grant, queue_count, grant_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        step(4'b0010, BURST_W'(0));
        checks++;
        if (queue_count !== 3'd1 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_enqueue: grant=%b qc=%0d, expected 0000 qc=1", grant, queue_count);
        end
        step(4'b0010, BURST_W'(0));
        step(4'b0010, BURST_W'(0));
        checks++;
        if (grant !== exp_grant) begin
            errors++;
            $display("FAIL zero_burst: grant=%b, expected %b", grant, exp_grant);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_pair();
        test_ordered();
        test_early_release();
        test_withdrawal();
        test_random();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
